serial_array_gates: RTL and testbench

SERIAL_ARRAY_GATES -- requirements
Module: serial_array_gates

---
 rtl/serial_array_gates.sv | 117 +++++++++++
 tb/tb_serial_array_gates.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_array_gates.sv
// Bit-serial two-operand gate unit: applies AND/OR/XOR/NAND one bit per cycle, LSB first,
// streams each result bit out and publishes the assembled word on o at completion.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; operands, op and result held
// S_SHIFT | one result bit per cycle, counter 0..WIDTH-1
// S_DONE  | done pulse for one cycle, o carries the new result
module serial_array_gates #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] o,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             gate_bit;
    logic             cnt_last;

    assign cnt_last = (cnt == CNT_LAST);

    always_comb begin
        gate_bit = 1'b0;
        case (op_q)
            2'b00:   gate_bit = a_sh[0] & b_sh[0];
            2'b01:   gate_bit = a_sh[0] | b_sh[0];
            2'b10:   gate_bit = a_sh[0] ^ b_sh[0];
            default: gate_bit = ~(a_sh[0] & b_sh[0]);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: if (cnt_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operands are only loaded in IDLE, so a start during SHIFT/DONE has no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            op_q   <= 2'b00;
            cnt    <= '0;
            o      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        op_q <= op;
                        cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    res_sh <= {gate_bit, res_sh[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    // The final bit is folded in directly so o is complete on entry to DONE.
                    if (cnt_last) begin
                        o <= {gate_bit, res_sh[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        bit_valid = (state == S_SHIFT);
        bit_out   = (state == S_SHIFT) & gate_bit;
        done      = (state == S_DONE);
    end

endmodule

// File: tb/tb_serial_array_gates.sv
// Directed bench for serial_array_gates: WIDTH=16 main instance plus WIDTH=2 and WIDTH=32
// instances for the width boundaries, all sharing one clock and reset.
module tb_serial_array_gates;

    logic clk;
    logic rst;

    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] o;
    logic        bit_out;
    logic        bit_valid;
    logic        busy;
    logic        done;

    logic        w2_start;
    logic [1:0]  w2_op;
    logic [1:0]  w2_a;
    logic [1:0]  w2_b;
    logic [1:0]  w2_o;
    logic        w2_bit_out;
    logic        w2_bit_valid;
    logic        w2_busy;
    logic        w2_done;

    logic        w32_start;
    logic [1:0]  w32_op;
    logic [31:0] w32_a;
    logic [31:0] w32_b;
    logic [31:0] w32_o;
    logic        w32_bit_out;
    logic        w32_bit_valid;
    logic        w32_busy;
    logic        w32_done;

    int checks;
    int errors;

    serial_array_gates #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .o(o),
        .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy), .done(done)
    );

    serial_array_gates #(.WIDTH(2)) dut_w2 (
        .clk(clk), .rst(rst), .start(w2_start), .op(w2_op), .a(w2_a), .b(w2_b), .o(w2_o),
        .bit_out(w2_bit_out), .bit_valid(w2_bit_valid), .busy(w2_busy), .done(w2_done)
    );

    serial_array_gates #(.WIDTH(32)) dut_w32 (
        .clk(clk), .rst(rst), .start(w32_start), .op(w32_op), .a(w32_a), .b(w32_b), .o(w32_o),
        .bit_out(w32_bit_out), .bit_valid(w32_bit_valid), .busy(w32_busy), .done(w32_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1; op = 2'b01; a = 16'hFFFF; b = 16'hFFFF;
        step();
        step();
        rst = 1'b0;
        start = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bit_valid !== 1'b0 || bit_out !== 1'b0 || o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b valid=%b bit=%b o=%h, required 0 0 0 0 0000",
                     busy, done, bit_valid, bit_out, o);
        end
        checks++;
        if (w2_busy !== 1'b0 || w2_o !== 2'b00 || w32_busy !== 1'b0 || w32_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_state_widths: w2_busy=%b w2_o=%b w32_busy=%b w32_o=%h, required 0 00 0 0",
                     w2_busy, w2_o, w32_busy, w32_o);
        end
    endtask

    task automatic test_and_serial();
        logic [15:0] exp_word;
        exp_word = 16'hA5A5;
        op = 2'b00; a = 16'hFFFF; b = 16'hA5A5; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (bit_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || bit_out !== exp_word[k] || o !== 16'h0000) begin
                errors++;
                $display("FAIL and_serial_bit%0d: valid=%b busy=%b done=%b bit=%b o=%h, required 1 1 0 %b 0000",
                         k, bit_valid, busy, done, bit_out, o, exp_word[k]);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || o !== 16'hA5A5 || bit_valid !== 1'b0 || bit_out !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL and_serial_done: done=%b o=%h valid=%b bit=%b busy=%b, required 1 a5a5 0 0 1",
                     done, o, bit_valid, bit_out, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || o !== 16'hA5A5) begin
            errors++;
            $display("FAIL and_serial_idle: done=%b busy=%b o=%h, required 0 0 a5a5", done, busy, o);
        end
    endtask

    task automatic test_gates();
        logic [1:0]  v_op  [3] = '{2'b10, 2'b11, 2'b01};
        logic [15:0] v_a   [3] = '{16'h1234, 16'h0000, 16'hF000};
        logic [15:0] v_b   [3] = '{16'h1234, 16'h0000, 16'h000F};
        logic [15:0] v_exp [3] = '{16'h0000, 16'hFFFF, 16'hF00F};
        logic [15:0] prev;
        logic        hold_ok;
        prev = 16'hA5A5;
        for (int i = 0; i < 3; i++) begin
            op = v_op[i]; a = v_a[i]; b = v_b[i]; start = 1'b1;
            step();
            start = 1'b0;
            a = ~v_a[i]; b = 16'h5A5A; op = ~v_op[i];
            hold_ok = 1'b1;
            for (int k = 0; k < 16; k++) begin
                if (o !== prev || done !== 1'b0) hold_ok = 1'b0;
                step();
            end
            checks++;
            if (!hold_ok) begin
                errors++;
                $display("FAIL gates_hold%0d: o changed or done early during shift, required o=%h held", i, prev);
            end
            checks++;
            if (done !== 1'b1 || o !== v_exp[i]) begin
                errors++;
                $display("FAIL gates_result%0d: done=%b o=%h, required 1 %h", i, done, o, v_exp[i]);
            end
            prev = v_exp[i];
            step();
        end
    endtask

    task automatic test_start_ignored();
        op = 2'b00; a = 16'hFFFF; b = 16'h00FF; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 5; k++) step();
        a = 16'h0000; op = 2'b01; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 6; k < 17; k++) step();
        checks++;
        if (done !== 1'b1 || o !== 16'h00FF) begin
            errors++;
            $display("FAIL start_ignored: done=%b o=%h, required 1 00ff", done, o);
        end
        step();
    endtask

    task automatic test_reset_abort();
        logic no_done;
        op = 2'b00; a = 16'hFFFF; b = 16'h0F0F; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 8; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || bit_valid !== 1'b0 || o !== 16'h0000 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b valid=%b o=%h done=%b, required 0 0 0000 0",
                     busy, bit_valid, o, done);
        end
        no_done = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (done !== 1'b0 || o !== 16'h0000) no_done = 1'b0;
            step();
        end
        checks++;
        if (!no_done) begin
            errors++;
            $display("FAIL reset_abort_no_done: done pulse or o update after abort, required none");
        end
        op = 2'b01; a = 16'h1200; b = 16'h0034; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 16; k++) step();
        checks++;
        if (done !== 1'b1 || o !== 16'h1234) begin
            errors++;
            $display("FAIL reset_recover: done=%b o=%h, required 1 1234", done, o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  v_op  [3] = '{2'b00, 2'b10, 2'b11};
        logic [15:0] v_a   [3] = '{16'hF0F0, 16'hAAAA, 16'hFFFF};
        logic [15:0] v_b   [3] = '{16'hFF00, 16'h5555, 16'h0F0F};
        logic [15:0] v_exp [3] = '{16'hF000, 16'hFFFF, 16'hF0F0};
        logic        shift_ok;
        op = v_op[0]; a = v_a[0]; b = v_b[0]; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i < 2) begin
                op = v_op[i+1]; a = v_a[i+1]; b = v_b[i+1];
            end else begin
                start = 1'b0; a = 16'h0000; b = 16'h0000;
            end
            shift_ok = 1'b1;
            for (int k = 0; k < 16; k++) begin
                if (done !== 1'b0 || busy !== 1'b1 || bit_valid !== 1'b1) shift_ok = 1'b0;
                step();
            end
            checks++;
            if (!shift_ok) begin
                errors++;
                $display("FAIL b2b_shift%0d: unexpected done/busy/valid during shift", i);
            end
            checks++;
            if (done !== 1'b1 || o !== v_exp[i]) begin
                errors++;
                $display("FAIL b2b_result%0d: done=%b o=%h, required 1 %h", i, done, o, v_exp[i]);
            end
            step();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle%0d: busy=%b done=%b, required 0 0", i, busy, done);
            end
        end
    endtask

    task automatic test_width2();
        logic [1:0] v_exp [4] = '{2'b10, 2'b11, 2'b01, 2'b01};
        logic       early;
        for (int i = 0; i < 4; i++) begin
            w2_op = 2'(i); w2_a = 2'b10; w2_b = 2'b11; w2_start = 1'b1;
            step();
            w2_start = 1'b0;
            early = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (w2_done !== 1'b0 || w2_bit_valid !== 1'b1) early = 1'b1;
                step();
            end
            checks++;
            if (early || w2_done !== 1'b1 || w2_o !== v_exp[i]) begin
                errors++;
                $display("FAIL width2_op%0d: early=%b done=%b o=%b, required 0 1 %b", i, early, w2_done, w2_o, v_exp[i]);
            end
            step();
        end
    endtask

    task automatic test_width32();
        logic [31:0] v_exp [4] = '{32'h0E0DB0E0, 32'hDFAFFEFF, 32'hD1A24E1F, 32'hF1F24F1F};
        logic        early;
        for (int i = 0; i < 4; i++) begin
            w32_op = 2'(i); w32_a = 32'hDEADBEEF; w32_b = 32'h0F0FF0F0; w32_start = 1'b1;
            step();
            w32_start = 1'b0;
            w32_a = 32'h0; w32_b = 32'hFFFFFFFF;
            early = 1'b0;
            for (int k = 0; k < 32; k++) begin
                if (w32_done !== 1'b0 || w32_bit_valid !== 1'b1) early = 1'b1;
                step();
            end
            checks++;
            if (early || w32_done !== 1'b1 || w32_o !== v_exp[i]) begin
                errors++;
                $display("FAIL width32_op%0d: early=%b done=%b o=%h, required 0 1 %h", i, early, w32_done, w32_o, v_exp[i]);
            end
            step();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0; op = 2'b00; a = '0; b = '0;
        w2_start = 1'b0; w2_op = 2'b00; w2_a = '0; w2_b = '0;
        w32_start = 1'b0; w32_op = 2'b00; w32_a = '0; w32_b = '0;
        test_reset();
        test_and_serial();
        test_gates();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_width2();
        test_width32();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
